// File: rtl/mulq_iter.sv
// mulq_iter: iterative 255x255 unsigned multiplier.
// Consumes one DIGIT_W-bit digit of b per cycle and accumulates the shifted
// partial products into a 510-bit accumulator. Valid/ready on both sides;
// the product is held in DONE until the consumer takes it.
module mulq_iter #(
    parameter int DIGIT_W = 51
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [254:0] a,
    input  logic [254:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [509:0] product_result
);

    localparam int NUM_DIGITS = 255 / DIGIT_W;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PP_W       = 255 + DIGIT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [254:0]       a_r;
    // b_r shifts right one digit per MUL cycle so the current digit is
    // always in the low DIGIT_W bits; no variable part-select is needed.
    logic [254:0]       b_r;
    logic [509:0]       acc;
    logic [CNT_W-1:0]   cnt;
    logic [PP_W-1:0]    pp;
    logic [509:0]       pp_shift;

    // Partial product of the full multiplicand with the current b digit,
    // aligned to the digit's weight.
    always_comb begin
        pp       = PP_W'(a_r) * PP_W'(b_r[DIGIT_W-1:0]);
        pp_shift = 510'(pp) << (cnt * DIGIT_W);
    end

    // Control FSM plus operand/accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc <= acc + pp_shift;
                    b_r <= b_r >> DIGIT_W;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NUM_DIGITS - 1)) begin
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // acc is the held result; nothing else changes here.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready       = (state == IDLE);
    assign product_result = acc;

endmodule

// File: tb/tb_mulq_iter.sv
// tb_mulq_iter: directed and random checks for mulq_iter at DIGIT_W=51.
module tb_mulq_iter;

    localparam int DW = 51;
    localparam int ND = 255 / DW;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [254:0] a;
    logic [254:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [509:0] product_result;

    int total = 0;
    int bad   = 0;
    int ops   = 0;
    int nacc  = 0;
    int nres  = 0;

    mulq_iter #(.DIGIT_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a              (a),
        .b              (b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .product_result (product_result)
    );

    always #5 clk = ~clk;

    // Independent handshake counters.
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) nacc <= nacc + 1;
        if (!rst && out_valid && out_ready) nres <= nres + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [509:0] obs, input logic [509:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [254:0] rnd255();
        logic [255:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return t[254:0];
    endfunction

    // One full operation: accept, wait for result, optional backpressure, handshake.
    task automatic run(input logic [254:0] ta, input logic [254:0] tv,
                       input logic [509:0] exp, input int stall,
                       input logic toggle, input string tag);
        int           cyc;
        logic         busy_ready;
        logic         unstable;
        logic [509:0] held;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_idle_ready"}, 510'(in_ready), 510'(1));
        a         = ta;
        b         = tv;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid   = 1'b0;
        ops++;
        cyc        = 0;
        busy_ready = 1'b0;
        while (!out_valid && cyc < 50) begin
            busy_ready |= in_ready;
            @(negedge clk);
            cyc++;
        end
        busy_ready |= in_ready;
        chk({tag, "_latency"}, 510'(cyc), 510'(ND));
        chk({tag, "_busy_in_ready"}, 510'(busy_ready), 510'(0));
        chk({tag, "_product"}, product_result, exp);
        held     = product_result;
        unstable = 1'b0;
        for (int i = 0; i < stall; i++) begin
            if (toggle) begin
                in_valid = $urandom_range(0, 1);
                a        = rnd255();
                b        = rnd255();
            end
            @(negedge clk);
            unstable |= !out_valid || in_ready || (product_result !== held);
        end
        if (stall > 0) chk({tag, "_hold"}, 510'(unstable), 510'(0));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_valid_drop"}, 510'(out_valid), 510'(0));
        chk({tag, "_ready_back"}, 510'(in_ready), 510'(1));
        out_ready = 1'b0;
    endtask

    initial begin
        logic [254:0] ones;
        logic [254:0] qm1;
        logic [254:0] ra;
        logic [254:0] rb;
        logic         saw;

        ones      = '1;
        qm1       = ones - 255'd19;   // q - 1 = 2^255 - 20
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        @(negedge clk);
        @(negedge clk);
        chk("reset_out_valid", 510'(out_valid), 510'(0));
        chk("reset_product", product_result, 510'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 510'(in_ready), 510'(1));

        run('0, ones, 510'(0), 0, 1'b0, "zero");
        // (2^255-1)^2 = 2^510 - 2^256 + 1
        run(ones, ones, 510'(0) - (510'(1) << 256) + 510'(1), 0, 1'b0, "allones");
        run(255'(1) << 254, 255'd2, 510'(1) << 255, 0, 1'b0, "pow2");
        // (2^255-20)^2 = 2^510 - 40*2^255 + 400
        run(qm1, qm1, 510'(400) - (510'(40) << 255), 0, 1'b0, "qm1sq");
        run(255'd123456789, 255'd987654321, 510'd121932631112635269, 20, 1'b1, "backpressure");

        // Abort an operation with reset while cnt = 2.
        a        = ones;
        b        = ones;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", 510'(out_valid), 510'(0));
        chk("abort_product", product_result, 510'(0));
        chk("abort_in_ready", 510'(in_ready), 510'(1));
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            saw |= out_valid;
        end
        chk("abort_no_result", 510'(saw), 510'(0));
        run(255'd3, 255'd5, 510'd15, 0, 1'b0, "after_abort");

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0:       begin ra = ones; rb = rnd255(); end
                1:       begin ra = rnd255(); rb = '0; end
                default: begin ra = rnd255(); rb = rnd255(); end
            endcase
            run(ra, rb, 510'(ra) * 510'(rb), $urandom_range(0, 3), 1'b1, "random");
        end

        @(negedge clk);
        chk("result_count", 510'(nres), 510'(ops));
        chk("accept_count", 510'(nacc), 510'(ops + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mulq_iter.md
Name: mulq_iter

Overview:
- Multi-cycle 255x255 unsigned multiplier. Produces the 510-bit raw product that feeds the mod-q reduction stage (q = 2^255 - 19) in the field-arithmetic datapath.
- It is the producer side of the product_result interface. It processes one DIGIT_W-bit digit of operand b per cycle, which trades latency for area compared with a single-cycle 255x255 array.
- Valid/ready handshake on both input and output. The result is held stable until the downstream stage accepts it.

Parameters:
- DIGIT_W, 51, width in bits of the b digit consumed per cycle. Must divide 255; legal values are 1, 3, 5, 15, 17, 51, 85, 255.
- NUM_DIGITS, 255/DIGIT_W, number of multiply cycles. Derived; do not override.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operands a, b are presented
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  255  multiplicand, full 255-bit range; values >= q are legal
- b  input  255  multiplier, full 255-bit range
- out_valid  output  1  product_result is valid and stable
- out_ready  input  1  downstream accepts product_result
- product_result  output  510  a*b, exact, unreduced

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE, out_valid=0, product_result=0, digit counter=0.
  - in_ready=1 in the first cycle after reset is released.
  - Reset overrides all other inputs. Asserting rst mid-operation aborts the multiply and discards it; no out_valid is produced for it.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a into A_r and b into B_r, clear the accumulator, set cnt=0, go to MUL.
  - in_valid=0 keeps the block in IDLE.
- State MUL:
  - in_ready=0; in_valid is ignored and operands are not sampled.
  - Each edge: acc <= acc + ((A_r * B_r[cnt*DIGIT_W +: DIGIT_W]) << (cnt*DIGIT_W)), then cnt <= cnt+1.
  - The accumulator is 510 bits; no overflow is possible.
  - On the edge that processes cnt = NUM_DIGITS-1: go to DONE and set out_valid=1.
- State DONE:
  - out_valid=1; product_result=acc, stable every cycle until the handshake completes.
  - On an edge with out_ready=1: out_valid goes 0 and state goes to IDLE.
  - out_ready=0 holds indefinitely (backpressure). a, b and in_valid changes have no effect.
- Latency: operands accepted at edge E0 give out_valid=1 immediately after edge E_NUM_DIGITS (5 cycles at the default).
  - in_ready returns high the cycle after the output handshake.
  - Minimum initiation interval is NUM_DIGITS+2 cycles. Operations never overlap.
- out_valid does not depend combinationally on out_ready. in_ready is a decode of the state register only.
- product_result is registered. Downstream may sample it on any edge where out_valid=1.
- DIGIT_W=255 degenerates to a one-cycle MUL state; the FSM sequence is unchanged.

Test Plan:
- Reset, then a=0, b=(2^255-1) -> out_valid exactly 5 cycles after acceptance, product_result=0; in_ready=0 throughout MUL/DONE.
- a=b=2^255-1, out_ready=1 -> product_result = 2^510 - 2^256 + 1; out_valid high for exactly 1 cycle; in_ready=1 on the next cycle.
- a=2^254, b=2 -> only product_result[255]=1. Then a=q-1, b=q-1 (q=2^255-19) -> (q-1)^2 exactly, checked against a reference model.
- Backpressure: result ready, out_ready=0 for 20 cycles while a, b and in_valid toggle -> product_result and out_valid unchanged and in_ready=0 throughout. out_ready=1 -> out_valid drops after that edge.
- Reset mid-op: rst=1 for 1 cycle at cnt=2 -> no out_valid; product_result=0 and in_ready=1 after release; the next operation (a=3, b=5) gives 15.
- 1000 random back-to-back operands with random out_ready stalls, at DIGIT_W=51, 17 and 255 -> every result equals a*b and the count of results equals the count of accepted inputs.
